kmeans_rand_idx: RTL and testbench

Parametrised random index generator for K-means initial centroid selection. A maximal-length Fibonacci LFSR of configurable width free-runs every cycle. On request, the block draws `k_count` distinct indices in `[0, n_points-1]` by rejection sampling and hands them out one at a time over a valid/ready interface. It sits between the control FSM and the centroid-init loader and generalises the fixed 13-bit random counter.

---
 rtl/kmeans_rand_idx.sv | 137 +++++++++++++
 tb/tb_kmeans_rand_idx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/kmeans_rand_idx.sv
// rtl/kmeans_rand_idx.sv - LFSR-based distinct random index generator for K-means centroid init
module kmeans_rand_idx #(
    parameter int               WIDTH = 13,
    parameter logic [WIDTH-1:0] TAPS  = 13'h100D,
    parameter int               K_MAX = 8,
    localparam int              KW    = $clog2(K_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             start,
    input  logic [WIDTH-1:0] n_points,
    input  logic [KW-1:0]    k_count,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] idx,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic             idx_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] n_reg;
    logic [KW-1:0]    k_reg;
    logic [KW-1:0]    issued;
    logic [WIDTH-1:0] tbl [K_MAX];
    logic [WIDTH-1:0] cand;
    logic             hit;
    logic             accept;
    logic             bad_req;

    assign cnt = lfsr;

    always_comb begin
        lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
        cand      = lfsr - WIDTH'(1);
    end

    // Only entries already handed out in this request take part in the distinctness check.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < K_MAX; i++) begin
            if ((KW'(i) < issued) && (tbl[i] == cand)) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        accept  = (lfsr <= n_reg) && !hit;
        bad_req = (n_points == '0) || (k_count == '0) ||
                  (32'(k_count) > K_MAX) || (32'(k_count) > 32'(n_points));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= WIDTH'(1);
            state     <= IDLE;
            n_reg     <= '0;
            k_reg     <= '0;
            issued    <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
            idx_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (seed_load) begin
                lfsr <= (seed == '0) ? WIDTH'(1) : seed;
            end else begin
                lfsr <= lfsr_next;
            end
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bad_req) begin
                            err <= 1'b1;
                        end else begin
                            n_reg  <= n_points;
                            k_reg  <= k_count;
                            issued <= '0;
                            busy   <= 1'b1;
                            state  <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    if (accept) begin
                        idx       <= cand;
                        idx_last  <= (KW'(issued + 1'b1) == k_reg);
                        idx_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (idx_ready) begin
                        issued    <= issued + 1'b1;
                        idx_valid <= 1'b0;
                        idx_last  <= 1'b0;
                        if (idx_last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= DRAW;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The table needs no reset: a fresh request restarts issued at 0, hiding stale entries.
    always_ff @(posedge clk) begin
        for (int i = 0; i < K_MAX; i++) begin
            if (!rst && (state == OUT) && idx_ready && (issued == KW'(i))) begin
                tbl[i] <= idx;
            end
        end
    end

endmodule

// File: tb/tb_kmeans_rand_idx.sv
// tb/tb_kmeans_rand_idx.sv - directed self-checking bench for kmeans_rand_idx
module tb_kmeans_rand_idx;

    localparam int WIDTH = 13;
    localparam int K_MAX = 8;
    localparam int KW    = $clog2(K_MAX + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             seed_load;
    logic [WIDTH-1:0] seed;
    logic             start;
    logic [WIDTH-1:0] n_points;
    logic [KW-1:0]    k_count;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] idx;
    logic             idx_valid;
    logic             idx_ready;
    logic             idx_last;
    logic             busy;
    logic             done;
    logic             err;

    kmeans_rand_idx #(.WIDTH(WIDTH), .TAPS(13'h100D), .K_MAX(K_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .start     (start),
        .n_points  (n_points),
        .k_count   (k_count),
        .cnt       (cnt),
        .idx       (idx),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .idx_last  (idx_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int               steps, cyc, hs, last_pos, last_cnt, done_cnt;
    logic             zero_seen, dup, busy_at_done, stable, held_last;
    logic [7:0]       mask;
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] vals [3];
    int               ek [4] = '{9, 0, 1, 5};
    int               en [4] = '{100, 100, 0, 4};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; seed_load = 1'b0; seed = '0; start = 1'b0;
        n_points = '0; k_count = '0; idx_ready = 1'b0;
        tick(); tick();
        check("rst_cnt", 32'(cnt), 32'h1);
        check("rst_idx", 32'(idx), 32'h0);
        check("rst_valid", 32'(idx_valid), 32'h0);
        check("rst_last", 32'(idx_last), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);

        // Free-running sequence and full period
        rst = 1'b0;
        tick(); check("lfsr_1", 32'(cnt), 32'h3);
        tick(); check("lfsr_2", 32'(cnt), 32'h7);
        tick(); check("lfsr_3", 32'(cnt), 32'hE);
        tick(); check("lfsr_4", 32'(cnt), 32'h1C);
        steps = 4; zero_seen = 1'b0;
        while (cnt != 1 && steps < 9000) begin
            tick(); steps++;
            if (cnt == 0) zero_seen = 1'b1;
        end
        check("lfsr_period", 32'(steps), 32'd8191);
        check("lfsr_nonzero", 32'(zero_seen), 32'h0);

        seed_load = 1'b1; seed = 13'h0ABC;
        tick(); check("seed_abc", 32'(cnt), 32'hABC);
        seed = '0;
        tick(); check("seed_zero", 32'(cnt), 32'h1);
        seed_load = 1'b0;

        // Full permutation of 0..7
        n_points = 13'd8; k_count = 4'd8; idx_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        check("perm_busy", 32'(busy), 32'h1);
        check("perm_valid0", 32'(idx_valid), 32'h0);
        hs = 0; mask = '0; last_pos = 0; last_cnt = 0; done_cnt = 0; cyc = 0;
        dup = 1'b0; busy_at_done = 1'b1;
        while (done_cnt == 0 && cyc < 70000) begin
            if (idx_valid) begin
                hs++;
                if (idx >= 8 || mask[idx[2:0]]) dup = 1'b1;
                mask[idx[2:0]] = 1'b1;
                if (idx_last) begin last_cnt++; last_pos = hs; end
            end
            tick(); cyc++;
            if (done) begin done_cnt++; busy_at_done = busy; end
        end
        check("perm_done_seen", 32'(done_cnt), 32'd1);
        check("perm_handshakes", 32'(hs), 32'd8);
        check("perm_set", 32'(mask), 32'hFF);
        check("perm_no_dup", 32'(dup), 32'h0);
        check("perm_last_cnt", 32'(last_cnt), 32'd1);
        check("perm_last_pos", 32'(last_pos), 32'd8);
        check("perm_busy_done", 32'(busy_at_done), 32'h0);
        tick();
        check("perm_done_pulse", 32'(done), 32'h0);

        // Backpressure: 20 stalled cycles per index
        n_points = 13'd100; k_count = 4'd3; idx_ready = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cyc = 0;
            while (!idx_valid && cyc < 20000) begin tick(); cyc++; end
            check("bp_valid", 32'(idx_valid), 32'h1);
            held = idx; held_last = idx_last; stable = 1'b1;
            for (int s = 0; s < 20; s++) begin
                tick();
                if (idx !== held || idx_valid !== 1'b1 || idx_last !== held_last) stable = 1'b0;
            end
            check("bp_stable", 32'(stable), 32'h1);
            check("bp_range", 32'(held < 100), 32'h1);
            check("bp_last", 32'(held_last), 32'(j == 2));
            vals[j] = held;
            idx_ready = 1'b1; tick(); idx_ready = 1'b0;
            check("bp_valid_drop", 32'(idx_valid), 32'h0);
        end
        check("bp_done", 32'(done), 32'h1);
        check("bp_busy", 32'(busy), 32'h0);
        check("bp_distinct", 32'(vals[0] != vals[1] && vals[0] != vals[2] && vals[1] != vals[2]), 32'h1);
        tick();

        // Rejected requests
        for (int e = 0; e < 4; e++) begin
            k_count = KW'(ek[e]); n_points = WIDTH'(en[e]); start = 1'b1;
            tick(); start = 1'b0;
            check("err_pulse", 32'(err), 32'h1);
            check("err_busy", 32'(busy), 32'h0);
            check("err_valid", 32'(idx_valid), 32'h0);
            tick();
            check("err_clear", 32'(err), 32'h0);
        end

        // start while busy is ignored
        n_points = 13'd100; k_count = 4'd1; start = 1'b1;
        tick(); start = 1'b0;
        check("busy_start", 32'(busy), 32'h1);
        k_count = 4'd0; start = 1'b1;
        tick(); start = 1'b0;
        check("busy_no_err", 32'(err), 32'h0);
        check("busy_held", 32'(busy), 32'h1);

        // Reset while an index is pending
        cyc = 0;
        while (!idx_valid && cyc < 20000) begin tick(); cyc++; end
        check("mid_valid", 32'(idx_valid), 32'h1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(idx_valid), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_cnt", 32'(cnt), 32'h1);
        rst = 1'b0;
        n_points = 13'd50; k_count = 4'd2; idx_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        hs = 0; done_cnt = 0; cyc = 0;
        while (done_cnt == 0 && cyc < 40000) begin
            if (idx_valid) hs++;
            tick(); cyc++;
            if (done) done_cnt++;
        end
        check("post_rst_done", 32'(done_cnt), 32'd1);
        check("post_rst_hs", 32'(hs), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
